bcd_seq_ctrl: RTL and testbench
===============================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: RR_START, default 0, meaning the round-robin pointer value (0..2) loaded at reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 3 bits: conversion requests, level; bit0 = seconds, bit1 = minutes, bit2 = hours.
REQ-005 The block SHALL have ports sec_bin, min_bin and hr_bin, input, 6 bits each: binary values 0..63.
REQ-006 The block SHALL have ports bcd_sec, bcd_min and bcd_hr, output, 8 bits each: registered two-digit BCD, tens in [7:4].
REQ-007 The block SHALL have port ack, output, 3 bits: one-cycle completion pulse per channel.
REQ-008 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle range-error pulse, coincident with ack.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-011 In IDLE, on an edge with at least one eligible request, the block SHALL grant one channel, load the 14-bit shift register {8'h00, bin_of_winner}, clear the bit counter and go to SHIFT. This edge is E0.
REQ-012 A channel SHALL be eligible when its req bit is 1 and its ack bit is 0 in that cycle.
REQ-013 Arbitration SHALL be round-robin: search starts at the pointer and proceeds pointer, pointer+1, pointer+2 (mod 3).
REQ-014 After each grant, the pointer SHALL become (granted index + 1) mod 3.
REQ-015 On each SHIFT edge (E1..E6), the block SHALL add 3 to every BCD nibble >= 5 and then shift the whole register left by 1.
REQ-016 After the 6th shift (E6), the FSM SHALL go to DONE.
REQ-017 At E7 (DONE), the block SHALL write the granted channel's bcd_* register, pulse its ack bit high for cycle E7..E8 and return to IDLE.
REQ-018 The earliest next grant SHALL occur at E8; the throughput is one conversion per 8 clocks.
REQ-019 The bin input SHALL be sampled only at E0; changes during SHIFT or DONE SHALL be ignored.
REQ-020 If req drops after the grant, the conversion SHALL still complete and ack SHALL still pulse.
REQ-021 If req drops before the grant, no conversion SHALL occur for that channel.
REQ-022 Non-granted bcd_* registers SHALL hold their values.
REQ-023 Exactly one ack bit at most SHALL be high in any cycle.
REQ-024 The BCD arithmetic SHALL be exact for all inputs 0..63 (for example, 63 -> 8'h63).

Reset
REQ-025 While rst_n = 0, the block SHALL immediately set: state IDLE, pointer = RR_START, shift register 0, counter 0, all bcd_* = 8'h00, ack = 3'b000, busy = 0, err = 0.
REQ-026 Reset asserted mid-SHIFT or mid-DONE SHALL abort the conversion with no ack and no bcd_* update.
REQ-027 The first grant SHALL be possible on the first rising edge after rst_n rises.

Configuration
REQ-028 The macro BCD_SEQ_CTRL_RANGE_CHK_EN SHALL control range checking.
REQ-029 With BCD_SEQ_CTRL_RANGE_CHK_EN defined, a sampled value > 59 (seconds or minutes) or > 23 (hours) SHALL cause the bcd_* write at E7 to be 8'hEE and err to pulse with ack. The latency SHALL be unchanged.
REQ-030 Without BCD_SEQ_CTRL_RANGE_CHK_EN, err SHALL be tied 0 and all values 0..63 SHALL convert normally.

Verification
REQ-031 The bench SHALL cover: sec_bin = 45, req = 3'b001 at E0 -> bcd_sec = 8'h45 and ack = 3'b001 during E7..E8 only; busy high E0..E7.
REQ-032 The bench SHALL cover: req = 3'b111 held with sec/min/hr = 59/30/23 and RR_START = 0 -> grants at E0, E8 and E16 in order sec, min, hr -> results 8'h59, 8'h30, 8'h23.
REQ-033 The bench SHALL cover: req[0] and req[1] held continuously -> acks alternate 001, 010, 001, 010 at 8-cycle spacing.
REQ-034 The bench SHALL cover: hr_bin = 63 -> with the macro, bcd_hr = 8'hEE and err = 1 with ack[2]; without the macro, bcd_hr = 8'h63 and err = 0.
REQ-035 The bench SHALL cover: rst_n pulsed low at E3 of a min_bin = 37 conversion -> no ack, bcd_min stays 8'h00, busy = 0 immediately, and a fresh request then yields 8'h37.
REQ-036 The bench SHALL cover: sec_bin changed from 12 to 50 at E2 -> bcd_sec = 8'h12.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: round-robin binary-to-BCD sequencer for sec/min/hr.
// One conversion per 8 clocks (grant, 6 shift-and-add-3 steps, write/ack).
// Ports: clk, rst_n (async, active-low); req[2:0] level requests
//   (bit0 sec, bit1 min, bit2 hr); sec_bin/min_bin/hr_bin 6-bit binary in;
//   bcd_sec/bcd_min/bcd_hr registered two-digit BCD out (tens in [7:4]);
//   ack[2:0] one-cycle done pulse; busy = not IDLE; err = range pulse.
// Parameter RR_START: arbitration pointer value after reset (0..2).
// Optional: define BCD_SEQ_CTRL_RANGE_CHK_EN to flag sec/min > 59 and
//   hr > 23; such results are written as 8'hEE with err pulsing with ack.
module bcd_seq_ctrl #(
    parameter int RR_START = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [5:0] sec_bin,
    input  logic [5:0] min_bin,
    input  logic [5:0] hr_bin,
    output logic [7:0] bcd_sec,
    output logic [7:0] bcd_min,
    output logic [7:0] bcd_hr,
    output logic [2:0] ack,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [13:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bcd_sec_q, bcd_sec_d;
    logic [7:0]  bcd_min_q, bcd_min_d;
    logic [7:0]  bcd_hr_q, bcd_hr_d;
    logic [2:0]  ack_q, ack_d;

    logic [2:0]  elig;
    logic [1:0]  c0, c1, c2;
    logic [1:0]  win;
    logic [5:0]  bin_win;
    logic [7:0]  res;

`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
    logic        rerr_q, rerr_d;
    logic        err_q, err_d;
    logic        rng_bad;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // A channel that is being acked this cycle is not eligible, so a
    // held request cannot immediately re-win right after completing.
    assign elig = req & ~ack_q;

    always_comb begin
        c0  = ptr_q;
        c1  = inc3(c0);
        c2  = inc3(c1);
        win = c2;
        if (elig[c0]) begin
            win = c0;
        end else if (elig[c1]) begin
            win = c1;
        end
    end

    always_comb begin
        bin_win = hr_bin;
        unique case (win)
            2'd0:    bin_win = sec_bin;
            2'd1:    bin_win = min_bin;
            default: bin_win = hr_bin;
        endcase
    end

`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
    assign rng_bad = (win == 2'd2) ? (bin_win > 6'd23)
                                   : (bin_win > 6'd59);
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        bcd_sec_d = bcd_sec_q;
        bcd_min_d = bcd_min_q;
        bcd_hr_d  = bcd_hr_q;
        ack_d     = 3'b000;
        res       = sr_q[13:6];
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
        rerr_d    = rerr_q;
        err_d     = 1'b0;
        if (rerr_q) begin
            res = 8'hEE;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    gnt_d   = win;
                    ptr_d   = inc3(win);
                    sr_d    = {8'h00, bin_win};
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
                    rerr_d  = rng_bad;
`endif
                end
            end
            SHIFT: begin
                // Double dabble: correct both digits, then shift left.
                sr_d  = {adj(sr_q[13:10]), adj(sr_q[9:6]), sr_q[5:0]} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                unique case (gnt_q)
                    2'd0: begin
                        bcd_sec_d = res;
                        ack_d     = 3'b001;
                    end
                    2'd1: begin
                        bcd_min_d = res;
                        ack_d     = 3'b010;
                    end
                    default: begin
                        bcd_hr_d  = res;
                        ack_d     = 3'b100;
                    end
                endcase
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
                err_d   = rerr_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'(RR_START);
            gnt_q     <= 2'd0;
            sr_q      <= 14'd0;
            cnt_q     <= 3'd0;
            bcd_sec_q <= 8'h00;
            bcd_min_q <= 8'h00;
            bcd_hr_q  <= 8'h00;
            ack_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            bcd_sec_q <= bcd_sec_d;
            bcd_min_q <= bcd_min_d;
            bcd_hr_q  <= bcd_hr_d;
            ack_q     <= ack_d;
        end
    end

`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rerr_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rerr_q <= rerr_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bcd_sec = bcd_sec_q;
    assign bcd_min = bcd_min_q;
    assign bcd_hr  = bcd_hr_q;
    assign ack     = ack_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: self-checking bench for bcd_seq_ctrl.
// Transaction-level model compared every cycle, plus literal checks.
module tb_bcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req = 3'b000;
    logic [5:0] sec_bin = 6'd0;
    logic [5:0] min_bin = 6'd0;
    logic [5:0] hr_bin = 6'd0;
    logic [7:0] bcd_sec, bcd_min, bcd_hr;
    logic [2:0] ack;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    bcd_seq_ctrl #(.RR_START(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sec_bin (sec_bin),
        .min_bin (min_bin),
        .hr_bin  (hr_bin),
        .bcd_sec (bcd_sec),
        .bcd_min (bcd_min),
        .bcd_hr  (bcd_hr),
        .ack     (ack),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_left = 0;
    int         m_ptr = 0;
    int         m_gnt = 0;
    int         m_val = 0;
    logic       m_bad = 1'b0;
    logic [7:0] m_bcd [3] = '{8'h00, 8'h00, 8'h00};
    logic [2:0] m_ack = 3'b000;
    logic       m_err = 1'b0;

    function automatic logic [7:0] enc(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int bin_of(input int ch);
        if (ch == 0) return int'(sec_bin);
        if (ch == 1) return int'(min_bin);
        return int'(hr_bin);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_left = 0;
                m_ptr  = 0;
                m_bcd  = '{8'h00, 8'h00, 8'h00};
                m_ack  = 3'b000;
                m_err  = 1'b0;
            end else begin
                logic [2:0] nack;
                logic       nerr;
                nack = 3'b000;
                nerr = 1'b0;
                if (m_left == 0) begin
                    logic [2:0] el;
                    bit found;
                    el = req & ~m_ack;
                    found = 0;
                    for (int i = 0; i < 3; i++) begin
                        int ch;
                        ch = (m_ptr + i) % 3;
                        if (!found && el[ch]) begin
                            found  = 1;
                            m_gnt  = ch;
                            m_val  = bin_of(ch);
                            m_left = 7;
                            m_ptr  = (ch + 1) % 3;
                        end
                    end
                    m_bad = (m_gnt == 2) ? (m_val > 23) : (m_val > 59);
                end else begin
                    m_left--;
                    if (m_left == 0) begin
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
                        m_bcd[m_gnt] = m_bad ? 8'hEE : enc(m_val);
                        nerr = m_bad;
`else
                        m_bcd[m_gnt] = enc(m_val);
`endif
                        nack[m_gnt] = 1'b1;
                    end
                end
                m_ack = nack;
                m_err = nerr;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("bcd_sec", bcd_sec, m_bcd[0]);
            chk("bcd_min", bcd_min, m_bcd[1]);
            chk("bcd_hr", bcd_hr, m_bcd[2]);
            chk("ack", {5'b0, ack}, {5'b0, m_ack});
            chk("busy", {7'b0, busy}, {7'b0, m_left != 0});
            chk("err", {7'b0, err}, {7'b0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        req = 3'b000;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bcd_sec", bcd_sec, 8'h00);
        chk("rst_bcd_hr", bcd_hr, 8'h00);
        chk("rst_ack", {5'b0, ack}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        #2 rst_n = 1'b1;

        // single seconds conversion, first edge after reset release
        sec_bin = 6'd45;
        req = 3'b001;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) req = 3'b000;
            chk("t1_ack", {5'b0, ack}, (k == 7) ? 8'h01 : 8'h00);
            chk("t1_busy", {7'b0, busy}, (k < 7) ? 8'h01 : 8'h00);
        end
        chk("t1_bcd_sec", bcd_sec, 8'h45);

        // all three requesting: sec, min, hr in order
        do_reset();
        sec_bin = 6'd59;
        min_bin = 6'd30;
        hr_bin  = 6'd23;
        req = 3'b111;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] e;
            @(negedge clk);
            if (k == 23) req = 3'b000;
            e = (k == 7) ? 8'h01 : (k == 15) ? 8'h02 :
                (k == 23) ? 8'h04 : 8'h00;
            chk("t2_ack", {5'b0, ack}, e);
        end
        chk("t2_sec", bcd_sec, 8'h59);
        chk("t2_min", bcd_min, 8'h30);
        chk("t2_hr", bcd_hr, 8'h23);

        // two channels held: alternate every 8 cycles
        do_reset();
        sec_bin = 6'd10;
        min_bin = 6'd9;
        req = 3'b011;
        for (int k = 0; k < 32; k++) begin
            logic [7:0] e;
            @(negedge clk);
            if (k == 31) req = 3'b000;
            e = (k % 8 != 7) ? 8'h00 : ((k / 8) % 2 == 1) ? 8'h02 : 8'h01;
            chk("t3_ack", {5'b0, ack}, e);
        end
        chk("t3_sec", bcd_sec, 8'h10);
        chk("t3_min", bcd_min, 8'h09);

        // hours out of range
        do_reset();
        hr_bin = 6'd63;
        req = 3'b100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) req = 3'b000;
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
            chk("t4_err", {7'b0, err}, (k == 7) ? 8'h01 : 8'h00);
`else
            chk("t4_err", {7'b0, err}, 8'h00);
`endif
        end
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
        chk("t4_hr", bcd_hr, 8'hEE);
`else
        chk("t4_hr", bcd_hr, 8'h63);
`endif

        // reset in the middle of a minutes conversion
        do_reset();
        min_bin = 6'd37;
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t5_busy_now", {7'b0, busy}, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_noack", {5'b0, ack}, 8'h00);
        end
        chk("t5_min_hold", bcd_min, 8'h00);
        req = 3'b010;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) req = 3'b000;
        end
        chk("t5_min", bcd_min, 8'h37);

        // input change after the grant is ignored
        do_reset();
        sec_bin = 6'd12;
        req = 3'b001;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) req = 3'b000;
            if (k == 1) sec_bin = 6'd50;
        end
        chk("t6_sec", bcd_sec, 8'h12);

        // held single request plus a short-lived min request while busy
        do_reset();
        sec_bin = 6'd7;
        req = 3'b001;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3) req = 3'b011;
            if (k == 4) req = 3'b001;
            chk("t7_nomin", {7'b0, ack[1]}, 8'h00);
        end
        req = 3'b000;
        repeat (10) @(negedge clk);
        chk("t7_min_hold", bcd_min, 8'h00);

        // sweep every value across the channels (model-checked)
        for (int v = 0; v < 64; v++) begin
            int ch;
            ch = v % 3;
            sec_bin = 6'(v);
            min_bin = 6'(v);
            hr_bin  = 6'(v);
            req = 3'(1 << ch);
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                if (k == 0) req = 3'b000;
            end
        end
`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN
        chk("sweep_63", bcd_sec, 8'hEE);
`else
        chk("sweep_63", bcd_sec, 8'h63);
`endif
        chk("sweep_62", bcd_hr, (`ifdef BCD_SEQ_CTRL_RANGE_CHK_EN 8'hEE
                                 `else 8'h62 `endif));

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
